// File: rtl/qdec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qdec_pkg
// Description : Shared definitions for the quadrature step decoder. Holds the
//               FSM state encoding, the forward phase-successor table, and a
//               lookup helper for that table.
//               Each phase state carries its {a,b} pair in bits [1:0], and
//               bit 2 marks the decoder as "running". This lets the FSM
//               recover the current phase, and load a new phase from the
//               inputs, without a separate decode step.
// Revision    : 1.0 - initial release
// ============================================================================
package qdec_pkg;

    typedef enum logic [2:0] {
        ST_INIT = 3'b000,
        ST_S00  = 3'b100,
        ST_S01  = 3'b101,
        ST_S11  = 3'b111,
        ST_S10  = 3'b110
    } qdec_state_e;

    // Forward successor of each {a,b} phase, packed by phase index:
    // 00->01, 01->11, 11->10, 10->00
    localparam logic [7:0] c_FWD_SUCC = {2'b10, 2'b00, 2'b11, 2'b01};

    // Width of the per-channel stability counter (FILT_LEN up to 15)
    localparam int FILT_CNT_W = 4;

    function automatic logic [1:0] fwd_succ(input logic [1:0] ab);
        return c_FWD_SUCC[{ab, 1'b0} +: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/qdec_filter.sv
`default_nettype none
// ============================================================================
// Module      : qdec_filter
// Description : Single-channel stability filter. The output follows the input
//               only after the input has differed from the output for
//               FILT_LEN consecutive samples. Shorter pulses are discarded.
//               Latency for an accepted change: FILT_LEN cycles.
// Ports       : clock   - system clock (rising edge)
//               rst     - synchronous active-high reset (output -> 0)
//               i_din   - synchronized input sample
//               o_dout  - filtered output
// Revision    : 1.0 - initial release
// ============================================================================
module qdec_filter
    import qdec_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic clock,
    input  logic rst,
    input  logic i_din,
    output logic o_dout
);

    localparam logic [FILT_CNT_W-1:0] c_LAST = FILT_CNT_W'(FILT_LEN - 1);

    logic [FILT_CNT_W-1:0] r_cnt;
    logic                  r_dout;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_cnt  <= '0;
            r_dout <= 1'b0;
        end else if (i_din != r_dout) begin
            // Accept on the FILT_LEN-th consecutive differing sample
            if (r_cnt == c_LAST) begin
                r_dout <= i_din;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/quad_step_decoder.sv
`default_nettype none
// ============================================================================
// Module      : quad_step_decoder
// Description : Quadrature encoder front end that drives an up/down counter.
//               The A/B/Z inputs pass through two-flop synchronizers and,
//               optionally, a per-channel stability filter. A phase FSM then
//               converts {a,b} changes into step/dir pulses. A rising edge on
//               Z issues a one-cycle load of the preset value.
//               Build option: define QUAD_FILTER_EN to insert the FILT_LEN
//               sample glitch filter. When it is undefined, the
//               synchronized signals feed the FSM directly.
// Ports       : clock     - system clock (rising edge)
//               rst       - synchronous active-high reset
//               enc_a/b   - asynchronous quadrature channels
//               enc_z     - asynchronous index channel
//               preset    - value captured on an index event (N bits)
//               clear_err - clears the sticky error flag
//               step      - one-cycle pulse per valid phase transition
//               dir       - 1 = up, 0 = down
//               load      - one-cycle pulse on index rising edge
//               load_val  - preset captured with load
//               err       - sticky illegal (two-bit) transition flag
// Revision    : 1.0 - initial release
// ============================================================================
module quad_step_decoder
    import qdec_pkg::*;
#(
    parameter int N        = 4,
    parameter int FILT_LEN = 3
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         enc_a,
    input  logic         enc_b,
    input  logic         enc_z,
    input  logic [N-1:0] preset,
    input  logic         clear_err,
    output logic         step,
    output logic         dir,
    output logic         load,
    output logic [N-1:0] load_val,
    output logic         err
);

    // The warm-up counter is sized for the filtered build in both builds,
    // so one counter serves either configuration.
    localparam int WCNT_W = $clog2(2 + FILT_LEN + 1);
`ifdef QUAD_FILTER_EN
    localparam int WARMUP = 2 + FILT_LEN;
`else
    localparam int WARMUP = 2;
`endif
    localparam logic [WCNT_W-1:0] c_WARMUP = WCNT_W'(WARMUP);

    // ------------------------------------------------------------------
    // Two-flop synchronizers, bit order {a, b, z}
    // ------------------------------------------------------------------
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_filt;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {enc_a, enc_b, enc_z};
            r_sync2 <= r_sync1;
        end
    end

`ifdef QUAD_FILTER_EN
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_filt
            qdec_filter #(
                .FILT_LEN (FILT_LEN)
            ) u_filter (
                .clock  (clock),
                .rst    (rst),
                .i_din  (r_sync2[gi]),
                .o_dout (w_filt[gi])
            );
        end
    endgenerate
`else
    assign w_filt = r_sync2;
`endif

    // ------------------------------------------------------------------
    // Transition classification against the current phase
    // ------------------------------------------------------------------
    qdec_state_e r_state;
    logic [WCNT_W-1:0] r_wcnt;
    logic        r_z_prev;
    logic        r_step;
    logic        r_dir;
    logic        r_load;
    logic [N-1:0] r_load_val;
    logic        r_err;

    logic [1:0] w_ab;
    logic [1:0] w_cur;
    logic       w_z;
    logic       w_run;
    logic       w_same;
    logic       w_fwd;
    logic       w_rev;
    logic       w_jump;
    logic       w_z_rise;

    always_comb begin
        w_ab     = w_filt[2:1];
        w_z      = w_filt[0];
        w_cur    = r_state[1:0];
        w_run    = (r_state != ST_INIT);
        w_same   = (w_ab == w_cur);
        w_fwd    = (fwd_succ(w_cur) == w_ab);
        w_rev    = (fwd_succ(w_ab) == w_cur);
        // Neither identical nor a neighbour: both bits flipped at once
        w_jump   = !w_same && !w_fwd && !w_rev;
        w_z_rise = w_z && !r_z_prev;
    end

    // ------------------------------------------------------------------
    // Phase FSM, pulse generation and index capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_wcnt     <= '0;
            r_z_prev   <= 1'b0;
            r_step     <= 1'b0;
            r_dir      <= 1'b1;
            r_load     <= 1'b0;
            r_load_val <= '0;
            r_err      <= 1'b0;
        end else begin
            r_step   <= 1'b0;
            r_load   <= 1'b0;
            // Tracked during warm-up as well, so a Z held high across the
            // end of warm-up does not appear as a fresh edge.
            r_z_prev <= w_z;

            if (!w_run) begin
                // Warm-up: wait until the input pipeline holds real samples,
                // then adopt the current phase silently.
                if (r_wcnt == c_WARMUP) begin
                    r_state <= qdec_state_e'({1'b1, w_ab});
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
                if (clear_err) begin
                    r_err <= 1'b0;
                end
            end else begin
                if (!w_same) begin
                    r_state <= qdec_state_e'({1'b1, w_ab});
                end

                if (w_fwd) begin
                    r_step <= 1'b1;
                    r_dir  <= 1'b1;
                end else if (w_rev) begin
                    r_step <= 1'b1;
                    r_dir  <= 1'b0;
                end

                // An illegal transition takes precedence over a clear
                if (w_jump) begin
                    r_err <= 1'b1;
                end else if (clear_err) begin
                    r_err <= 1'b0;
                end

                if (w_z_rise) begin
                    r_load     <= 1'b1;
                    r_load_val <= preset;
                end
            end
        end
    end

    assign step     = r_step;
    assign dir      = r_dir;
    assign load     = r_load;
    assign load_val = r_load_val;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_step_decoder
// Description : Directed self-checking bench for quad_step_decoder. It covers
//               reset state, forward and reverse stepping with latency,
//               illegal jumps with the sticky error and its clear, index
//               loads, a coincident load and step, and reset mid-stream.
//               The glitch-filter case is included when QUAD_FILTER_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_step_decoder;

    localparam int N        = 4;
    localparam int FILT_LEN = 3;
`ifdef QUAD_FILTER_EN
    localparam int LAT = 3 + FILT_LEN;
`else
    localparam int LAT = 3;
`endif

    logic         clock;
    logic         rst;
    logic         enc_a;
    logic         enc_b;
    logic         enc_z;
    logic [N-1:0] preset;
    logic         clear_err;
    logic         step;
    logic         dir;
    logic         load;
    logic [N-1:0] load_val;
    logic         err;

    int n_total;
    int n_bad;

    // Observations gathered by run_ab
    int s_cnt;
    int s_first;
    int l_cnt;
    int l_first;
    int e_cnt;

    quad_step_decoder #(
        .N        (N),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .enc_z     (enc_z),
        .preset    (preset),
        .clear_err (clear_err),
        .step      (step),
        .dir       (dir),
        .load      (load),
        .load_val  (load_val),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Drive {a,b}, run span cycles, and record step/load/err activity.
    // Cycle index i counts clock edges after the input change.
    task automatic run_ab(input logic [1:0] ab, input int span);
        enc_a   = ab[1];
        enc_b   = ab[0];
        s_cnt   = 0;
        s_first = -1;
        l_cnt   = 0;
        l_first = -1;
        e_cnt   = 0;
        for (int i = 1; i <= span; i++) begin
            tick();
            if (step) begin
                s_cnt++;
                if (s_first < 0) s_first = i;
            end
            if (load) begin
                l_cnt++;
                if (l_first < 0) l_first = i;
            end
            if (err) e_cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] fwd_seq [4];
        n_total   = 0;
        n_bad     = 0;
        fwd_seq   = '{2'b01, 2'b11, 2'b10, 2'b00};
        rst       = 1'b1;
        enc_a     = 1'b0;
        enc_b     = 1'b0;
        enc_z     = 1'b0;
        preset    = '0;
        clear_err = 1'b0;
        repeat (3) tick();

        check("rst_step", step, 0);
        check("rst_load", load, 0);
        check("rst_err", err, 0);
        check("rst_dir", dir, 1);
        check("rst_load_val", load_val, 0);

        // Warm-up with ab=00: silent
        rst = 1'b0;
        run_ab(2'b00, 10);
        check("warm_step", s_cnt, 0);
        check("warm_err", e_cnt, 0);

        // Forward cycle 00->01->11->10->00
        for (int k = 0; k < 4; k++) begin
            run_ab(fwd_seq[k], 8);
            check("fwd_nstep", s_cnt, 1);
            check("fwd_lat", s_first, LAT);
            check("fwd_dir", dir, 1);
        end

        // Reverse 00->10->11
        run_ab(2'b10, 8);
        check("rev1_nstep", s_cnt, 1);
        check("rev1_lat", s_first, LAT);
        check("rev1_dir", dir, 0);
        run_ab(2'b11, 8);
        check("rev2_nstep", s_cnt, 1);
        check("rev2_dir", dir, 0);

        // Back to 00 by reverse steps
        run_ab(2'b01, 8);
        run_ab(2'b00, 8);
        check("rev4_nstep", s_cnt, 1);
        check("rev4_dir", dir, 0);

        // Illegal jump 00->11
        run_ab(2'b11, 8);
        check("jump_nstep", s_cnt, 0);
        check("jump_err", err, 1);
        check("jump_dir", dir, 0);

        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clr_err", err, 0);

        // Jump 11->00 with clear_err landing on the same cycle the FSM sees it
        enc_a = 1'b0;
        enc_b = 1'b0;
        repeat (LAT - 1) tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clr_vs_jump_err", err, 1);
        check("clr_vs_jump_step", step, 0);
        repeat (4) tick();

        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clr2_err", err, 0);

        // Index: z held 20 cycles -> single load of 4'hA
        preset = 4'hA;
        enc_z  = 1'b1;
        run_ab(2'b00, 20);
        check("idx_nload", l_cnt, 1);
        check("idx_lat", l_first, LAT);
        check("idx_val", load_val, 4'hA);
        check("idx_nstep", s_cnt, 0);

        preset = 4'h3;
        run_ab(2'b00, 5);
        check("idx_hold_val", load_val, 4'hA);
        check("idx_hold_nload", l_cnt, 0);

        enc_z = 1'b0;
        run_ab(2'b00, 6);

        // Coincident index edge and forward step
        enc_z = 1'b1;
        run_ab(2'b01, 8);
        check("both_step_lat", s_first, LAT);
        check("both_load_lat", l_first, LAT);
        check("both_val", load_val, 4'h3);
        enc_z = 1'b0;
        run_ab(2'b11, 8);
        check("fwd5_dir", dir, 1);

        // Reset mid-stream: a pending step toward 10 must be dropped
        enc_a = 1'b1;
        enc_b = 1'b0;
        tick();
        tick();
        rst   = 1'b1;
        enc_b = 1'b1;
        tick();
        check("mid_rst_step", step, 0);
        check("mid_rst_dir", dir, 1);
        tick();
        rst = 1'b0;
        run_ab(2'b11, 12);
        check("post_rst_nstep", s_cnt, 0);
        check("post_rst_nerr", e_cnt, 0);
        check("post_rst_dir", dir, 1);
        check("post_rst_err", err, 0);

`ifdef QUAD_FILTER_EN
        // 2-cycle glitch on a is rejected
        enc_a = 1'b0;
        tick();
        tick();
        enc_a = 1'b1;
        run_ab(2'b11, 12);
        check("glitch_nstep", s_cnt, 0);
        // Stable change is accepted after the filter delay
        run_ab(2'b01, 12);
        check("filt_nstep", s_cnt, 1);
        check("filt_lat", s_first, LAT);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
